// File: rtl/bvm_bus_master.sv
// BVM-A option-slot bus initiator: turns single-byte register requests into
// SYNC/CMD/REG/DATA frames, captures card read data and synchronises int_x.
module bvm_bus_master #(
  parameter int unsigned HALF_CLKS = 25,
  parameter int unsigned GAP_BEATS = 2
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_init,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       irq_pending,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       slot_x_int_x,
  output logic [7:0] data_out_x,
  output logic       data_oe_x,
  input  logic [7:0] data_in_x,
  input  logic       int_x
);

  localparam int unsigned HW = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam int unsigned BW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CLKS - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_CMD, S_REG, S_DATA, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q;
  logic          high_q;
  logic [BW-1:0] beat_q;
  logic          ready_en_q;
  logic          write_q, init_q;
  logic [7:0]    cmd_q, reg_q, wdata_q;
  logic          irq_meta_q;
  logic          half_end, beat_end, accept, in_frame;

  assign req_ready = (state_q == S_IDLE) && ready_en_q;
  assign accept    = req_valid && req_ready;
  assign half_end  = (half_q == HALF_LAST);
  assign beat_end  = half_end && high_q;
  assign in_frame  = (state_q == S_SYNC) || (state_q == S_CMD) ||
                     (state_q == S_REG)  || (state_q == S_DATA);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)   state_d = S_SYNC;
      S_SYNC: if (beat_end) state_d = S_CMD;
      S_CMD:  if (beat_end) state_d = S_REG;
      S_REG:  if (beat_end) state_d = S_DATA;
      S_DATA: if (beat_end) state_d = (GAP_BEATS == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (beat_end && (beat_q == BEAT_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= S_IDLE;
      half_q      <= '0;
      high_q      <= 1'b0;
      beat_q      <= '0;
      ready_en_q  <= 1'b0;
      write_q     <= 1'b0;
      init_q      <= 1'b0;
      cmd_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      irq_meta_q  <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      // Half/beat counters free-run only outside IDLE; beat boundaries wrap them to 0.
      if (state_q == S_IDLE) begin
        half_q <= '0;
        high_q <= 1'b0;
        beat_q <= '0;
      end else begin
        half_q <= half_end ? '0 : half_q + 1'b1;
        if (half_end) high_q <= ~high_q;
        if ((state_q == S_GAP) && beat_end) beat_q <= beat_q + 1'b1;
      end
      if (accept) begin
        write_q <= req_write;
        init_q  <= req_init;
        cmd_q   <= req_cmd;
        reg_q   <= req_reg;
        wdata_q <= req_wdata;
      end
      rsp_valid <= (state_q == S_DATA) && beat_end;
      if ((state_q == S_DATA) && !write_q && !high_q && half_end)
        rsp_rdata <= ~data_in_x;
      else if ((state_q == S_DATA) && write_q && beat_end)
        rsp_rdata <= '0;
      irq_meta_q  <= ~int_x;
      irq_pending <= irq_meta_q;
    end
  end

  always_comb begin
    clk_rw       = 1'b1;
    ax_d         = 1'b1;
    r_wx         = 1'b1;
    data_oe_x    = 1'b1;
    data_out_x   = '1;
    slot_x_int_x = 1'b1;
    if (in_frame) begin
      clk_rw       = high_q;
      slot_x_int_x = ~init_q;
      data_oe_x    = 1'b0;
      ax_d         = 1'b0;
      r_wx         = 1'b0;
    end
    case (state_q)
      S_SYNC: begin
        r_wx       = 1'b1;
        data_out_x = '0;
      end
      S_CMD: data_out_x = ~cmd_q;
      S_REG: data_out_x = ~reg_q;
      S_DATA: begin
        ax_d = 1'b1;
        if (write_q) begin
          data_out_x = ~wdata_q;
        end else begin
          r_wx      = 1'b1;
          data_oe_x = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
